i2c_cfg_seq: RTL



---
 rtl/i2c_cfg_seq.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_cfg_seq.sv
// rtl/i2c_cfg_seq.sv - table-driven I2C register initialisation sequencer
// Walks a (reg, data) table, issuing a write (and optional readback) per entry with retries.
module i2c_cfg_seq #(
  parameter logic [7:0] DEV_ADDR   = 8'hBA,
  parameter int         TBL_AW     = 6,
  parameter int         PWRUP_CYC  = 50,
  parameter int         DELAY_UNIT = 50000,
  parameter int         MAX_RETRY  = 3,
  parameter int         VERIFY     = 1
) (
  input  logic              sys_clk_50mhz,
  input  logic              reset_n,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_wr,
  output logic [7:0]        cmd_dev,
  output logic [7:0]        cmd_reg,
  output logic [15:0]       cmd_wdata,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  input  logic [15:0]       rsp_rdata,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [TBL_AW-1:0] err_index,
  output logic [TBL_AW:0]   entry_cnt
);

  typedef enum logic [3:0] {
    IDLE, PWRUP, FETCH, DECODE, ISSUE_WR, WAIT_WR,
    ISSUE_RD, WAIT_RD, CHECK, DELAY, DONE, ERROR
  } state_t;

  localparam logic [TBL_AW-1:0] IDX_LAST = '1;
  localparam logic [TBL_AW-1:0] IDX_ONE  = 1;
  localparam logic [TBL_AW:0]   CNT_ONE  = 1;

  state_t              state_q, state_d;
  logic [TBL_AW-1:0]   idx_q, idx_d;
  logic [7:0]          retry_q, retry_d;
  logic [16:0]         ucnt_q, ucnt_d;
  logic [15:0]         tick_q, tick_d;
  logic [15:0]         ent_data_q, ent_data_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [7:0]          cmd_reg_q, cmd_reg_d;
  logic [15:0]         cmd_wdata_q, cmd_wdata_d;
  logic                busy_q, busy_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_err_q, cfg_err_d;
  logic [TBL_AW-1:0]   err_index_q, err_index_d;
  logic [TBL_AW:0]     entry_cnt_q, entry_cnt_d;
  logic                do_complete, do_fail;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    ucnt_d      = ucnt_q;
    tick_d      = tick_q;
    ent_data_d  = ent_data_q;
    rdata_d     = rdata_q;
    cmd_valid_d = cmd_valid_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_wdata_d = cmd_wdata_q;
    busy_d      = busy_q;
    cfg_done_d  = cfg_done_q;
    cfg_err_d   = cfg_err_q;
    err_index_d = err_index_q;
    entry_cnt_d = entry_cnt_q;
    do_complete = 1'b0;
    do_fail     = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          cfg_done_d  = 1'b0;
          cfg_err_d   = 1'b0;
          err_index_d = '0;
          entry_cnt_d = '0;
          idx_d       = '0;
          retry_d     = '0;
          ucnt_d      = '0;
          busy_d      = 1'b1;
          state_d     = PWRUP;
        end
      end
      PWRUP: begin
        if (ucnt_q == 17'(PWRUP_CYC - 1)) begin
          ucnt_d  = '0;
          state_d = FETCH;
        end else begin
          ucnt_d = ucnt_q + 17'd1;
        end
      end
      FETCH: state_d = DECODE;
      // tbl_data has settled by now: tbl_addr was stable through the FETCH clock
      DECODE: begin
        ent_data_d = tbl_data[15:0];
        if (tbl_data[23:16] == 8'hFF) begin
          state_d    = DONE;
          cfg_done_d = 1'b1;
          busy_d     = 1'b0;
        end else if (tbl_data[23:16] == 8'hFE) begin
          if (tbl_data[15:0] == 16'd0) begin
            do_complete = 1'b1;
          end else begin
            ucnt_d  = '0;
            tick_d  = '0;
            state_d = DELAY;
          end
        end else begin
          cmd_valid_d = 1'b1;
          cmd_wr_d    = 1'b1;
          cmd_reg_d   = tbl_data[23:16];
          cmd_wdata_d = tbl_data[15:0];
          state_d     = ISSUE_WR;
        end
      end
      ISSUE_WR: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_WR;
        end
      end
      WAIT_WR: begin
        if (rsp_valid) begin
          if (rsp_nack) begin
            do_fail = 1'b1;
          end else if (VERIFY != 0) begin
            cmd_valid_d = 1'b1;
            cmd_wr_d    = 1'b0;
            state_d     = ISSUE_RD;
          end else begin
            do_complete = 1'b1;
          end
        end
      end
      ISSUE_RD: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (rsp_valid) begin
          if (rsp_nack) begin
            do_fail = 1'b1;
          end else begin
            rdata_d = rsp_rdata;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (rdata_q == ent_data_q) do_complete = 1'b1;
        else                       do_fail     = 1'b1;
      end
      DELAY: begin
        if (ucnt_q == 17'(DELAY_UNIT - 1)) begin
          ucnt_d = '0;
          if (tick_q == ent_data_q - 16'd1) do_complete = 1'b1;
          else                              tick_d = tick_q + 16'd1;
        end else begin
          ucnt_d = ucnt_q + 17'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A retry rewrites the same entry; cmd_reg/cmd_wdata still hold it
    if (do_fail) begin
      if (retry_q < 8'(MAX_RETRY)) begin
        retry_d     = retry_q + 8'd1;
        cmd_valid_d = 1'b1;
        cmd_wr_d    = 1'b1;
        state_d     = ISSUE_WR;
      end else begin
        cfg_err_d   = 1'b1;
        err_index_d = idx_q;
        busy_d      = 1'b0;
        state_d     = ERROR;
      end
    end

    if (do_complete) begin
      entry_cnt_d = entry_cnt_q + CNT_ONE;
      retry_d     = '0;
      if (idx_q == IDX_LAST) begin
        cfg_done_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = DONE;
      end else begin
        idx_d   = idx_q + IDX_ONE;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge sys_clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      retry_q     <= '0;
      ucnt_q      <= '0;
      tick_q      <= '0;
      ent_data_q  <= '0;
      rdata_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_reg_q   <= '0;
      cmd_wdata_q <= '0;
      busy_q      <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      err_index_q <= '0;
      entry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      ucnt_q      <= ucnt_d;
      tick_q      <= tick_d;
      ent_data_q  <= ent_data_d;
      rdata_q     <= rdata_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_wdata_q <= cmd_wdata_d;
      busy_q      <= busy_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
      err_index_q <= err_index_d;
      entry_cnt_q <= entry_cnt_d;
    end
  end

  assign tbl_addr  = idx_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_dev   = DEV_ADDR;
  assign cmd_reg   = cmd_reg_q;
  assign cmd_wdata = cmd_wdata_q;
  assign busy      = busy_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign err_index = err_index_q;
  assign entry_cnt = entry_cnt_q;

endmodule
